// File: rtl/tl_pkg.sv
// Shared TileLink definitions for the parametrised pass-through buffer:
// opcode constants plus width helpers for the packed A/D payloads and counters.
package tl_pkg;

  localparam logic [2:0] TL_A_PUT_FULL_DATA   = 3'd0;
  localparam logic [2:0] TL_A_GET             = 3'd4;
  localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // A payload: opcode(3) param(3) size source address mask data corrupt(1)
  function automatic int tl_a_w(input int size_w, input int src_w,
                                input int addr_w, input int data_w);
    return 7 + size_w + src_w + addr_w + data_w / 8 + data_w;
  endfunction

  // D payload: opcode(3) param(2) size source sink denied(1) data corrupt(1)
  function automatic int tl_d_w(input int size_w, input int src_w,
                                input int sink_w, input int data_w);
    return 7 + size_w + src_w + sink_w + data_w;
  endfunction

  // Occupancy counter width; a wire-only channel still gets a 1-bit count.
  function automatic int tl_cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Pointer width; a single-entry queue keeps a 1-bit pointer that stays 0.
  function automatic int tl_ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/tl_queue.sv
// Generic ready/valid FIFO with optional flow-through and pipe modes.
// DEPTH 0 collapses to wires; any DEPTH >= 1 (power of two or not) is supported.
module tl_queue
  import tl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int FLOW  = 0,
  parameter int PIPE  = 0,
  parameter int CNT_W = tl_cnt_w(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_valid_i,
  output logic             enq_ready_o,
  input  logic [WIDTH-1:0] enq_bits_i,
  output logic             deq_valid_o,
  input  logic             deq_ready_i,
  output logic [WIDTH-1:0] deq_bits_o,
  output logic [CNT_W-1:0] count_o
);

  if (DEPTH == 0) begin : g_wire
    assign enq_ready_o = deq_ready_i;
    assign deq_valid_o = enq_valid_i;
    assign deq_bits_o  = enq_bits_i;
    assign count_o     = '0;
  end else begin : g_fifo
    localparam int              PTR_W    = tl_ptr_w(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] enq_ptr_q, enq_ptr_d;
    logic [PTR_W-1:0] deq_ptr_q, deq_ptr_d;
    logic             maybe_full_q, maybe_full_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic ptr_match_s, empty_s, full_s, bypass_s, do_enq_s, do_deq_s;

    assign ptr_match_s = (enq_ptr_q == deq_ptr_q);
    assign empty_s     = ptr_match_s && !maybe_full_q;
    assign full_s      = ptr_match_s && maybe_full_q;
    assign bypass_s    = (FLOW != 0) && empty_s;

    // Handshake outputs; valid never looks at ready, only ready->ready in pipe mode.
    always_comb begin
      enq_ready_o = !full_s || ((PIPE != 0) && deq_ready_i);
      if (bypass_s) begin
        deq_valid_o = enq_valid_i;
        deq_bits_o  = enq_bits_i;
      end else begin
        deq_valid_o = !empty_s;
        deq_bits_o  = mem_q[deq_ptr_q];
      end
    end

    // Fire decode; a bypassed beat is consumed downstream without touching state.
    always_comb begin
      if (bypass_s && deq_ready_i) begin
        do_enq_s = 1'b0;
        do_deq_s = 1'b0;
      end else begin
        do_enq_s = enq_valid_i && enq_ready_o;
        do_deq_s = deq_valid_o && deq_ready_i;
      end
    end

    // Next-state for pointers (modulo DEPTH) and the full/empty disambiguation flag.
    always_comb begin
      if (do_enq_s) begin
        enq_ptr_d = (enq_ptr_q == PTR_LAST) ? '0 : enq_ptr_q + 1'b1;
      end else begin
        enq_ptr_d = enq_ptr_q;
      end
      if (do_deq_s) begin
        deq_ptr_d = (deq_ptr_q == PTR_LAST) ? '0 : deq_ptr_q + 1'b1;
      end else begin
        deq_ptr_d = deq_ptr_q;
      end
      if (do_enq_s != do_deq_s) begin
        maybe_full_d = do_enq_s;
      end else begin
        maybe_full_d = maybe_full_q;
      end
    end

    // Occupancy from registered pointers only; equal pointers mean 0 or DEPTH.
    always_comb begin
      if (full_s) begin
        count_o = CNT_W'(DEPTH);
      end else if (enq_ptr_q >= deq_ptr_q) begin
        count_o = CNT_W'(enq_ptr_q - deq_ptr_q);
      end else begin
        count_o = CNT_W'(DEPTH + int'(enq_ptr_q) - int'(deq_ptr_q));
      end
    end

    // Control state; reset empties the queue and discards held beats.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        enq_ptr_q    <= '0;
        deq_ptr_q    <= '0;
        maybe_full_q <= 1'b0;
      end else begin
        enq_ptr_q    <= enq_ptr_d;
        deq_ptr_q    <= deq_ptr_d;
        maybe_full_q <= maybe_full_d;
      end
    end

    // Payload storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
      if (do_enq_s) begin
        mem_q[enq_ptr_q] <= enq_bits_i;
      end
    end
  end

endmodule

// File: rtl/tl_buffer_param.sv
// TL-UH buffer between a client (in) and a manager (out): one independent
// queue on A (client -> manager) and one on D (manager -> client).
module tl_buffer_param
  import tl_pkg::*;
#(
  parameter int  ADDR_W  = 32,
  parameter int  DATA_W  = 64,
  parameter int  SRC_W   = 3,
  parameter int  SINK_W  = 2,
  parameter int  SIZE_W  = 4,
  parameter int  A_DEPTH = 2,
  parameter int  D_DEPTH = 2,
  parameter int  A_FLOW  = 0,
  parameter int  D_FLOW  = 0,
  parameter int  A_PIPE  = 0,
  parameter int  D_PIPE  = 0,
  localparam int A_W     = tl_a_w(SIZE_W, SRC_W, ADDR_W, DATA_W),
  localparam int D_W     = tl_d_w(SIZE_W, SRC_W, SINK_W, DATA_W),
  localparam int A_CNT_W = tl_cnt_w(A_DEPTH),
  localparam int D_CNT_W = tl_cnt_w(D_DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               auto_in_a_valid,
  output logic               auto_in_a_ready,
  input  logic [A_W-1:0]     auto_in_a_bits,
  output logic               auto_out_a_valid,
  input  logic               auto_out_a_ready,
  output logic [A_W-1:0]     auto_out_a_bits,
  input  logic               auto_out_d_valid,
  output logic               auto_out_d_ready,
  input  logic [D_W-1:0]     auto_out_d_bits,
  output logic               auto_in_d_valid,
  input  logic               auto_in_d_ready,
  output logic [D_W-1:0]     auto_in_d_bits,
  output logic [A_CNT_W-1:0] a_count,
  output logic [D_CNT_W-1:0] d_count
);

  tl_queue #(
    .WIDTH (A_W),
    .DEPTH (A_DEPTH),
    .FLOW  (A_FLOW),
    .PIPE  (A_PIPE)
  ) u_a_queue (
    .clk_i       (clock),
    .rst_i       (reset),
    .enq_valid_i (auto_in_a_valid),
    .enq_ready_o (auto_in_a_ready),
    .enq_bits_i  (auto_in_a_bits),
    .deq_valid_o (auto_out_a_valid),
    .deq_ready_i (auto_out_a_ready),
    .deq_bits_o  (auto_out_a_bits),
    .count_o     (a_count)
  );

  tl_queue #(
    .WIDTH (D_W),
    .DEPTH (D_DEPTH),
    .FLOW  (D_FLOW),
    .PIPE  (D_PIPE)
  ) u_d_queue (
    .clk_i       (clock),
    .rst_i       (reset),
    .enq_valid_i (auto_out_d_valid),
    .enq_ready_o (auto_out_d_ready),
    .enq_bits_i  (auto_out_d_bits),
    .deq_valid_o (auto_in_d_valid),
    .deq_ready_i (auto_in_d_ready),
    .deq_bits_o  (auto_in_d_bits),
    .count_o     (d_count)
  );

endmodule

// File: tb/tb_tl_buffer_param.sv
// Bench for tl_buffer_param: four instances cover default depth-2 queues,
// flow/depth-3, pipe/depth-1 and pure-wire configurations.
module tb_tl_buffer_param;
  import tl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Per-instance handshake signals: [0] default, [1] A1 flow/D3, [2] A1 pipe/D0, [3] A0/D0
  logic         in_a_valid  [4];
  logic         in_a_ready  [4];
  logic [117:0] in_a_bits   [4];
  logic         out_a_valid [4];
  logic         out_a_ready [4];
  logic [117:0] out_a_bits  [4];
  logic         out_d_valid [4];
  logic         out_d_ready [4];
  logic [79:0]  out_d_bits  [4];
  logic         in_d_valid  [4];
  logic         in_d_ready  [4];
  logic [79:0]  in_d_bits   [4];
  logic [1:0]   a_cnt0, d_cnt0, d_cnt1;
  logic [0:0]   a_cnt1, a_cnt2, d_cnt2, a_cnt3, d_cnt3;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] sb_q[$];

  tl_buffer_param u_dut0 (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid[0]), .auto_in_a_ready(in_a_ready[0]), .auto_in_a_bits(in_a_bits[0]),
    .auto_out_a_valid(out_a_valid[0]), .auto_out_a_ready(out_a_ready[0]), .auto_out_a_bits(out_a_bits[0]),
    .auto_out_d_valid(out_d_valid[0]), .auto_out_d_ready(out_d_ready[0]), .auto_out_d_bits(out_d_bits[0]),
    .auto_in_d_valid(in_d_valid[0]), .auto_in_d_ready(in_d_ready[0]), .auto_in_d_bits(in_d_bits[0]),
    .a_count(a_cnt0), .d_count(d_cnt0));

  tl_buffer_param #(.A_DEPTH(1), .A_FLOW(1), .D_DEPTH(3)) u_dut1 (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid[1]), .auto_in_a_ready(in_a_ready[1]), .auto_in_a_bits(in_a_bits[1]),
    .auto_out_a_valid(out_a_valid[1]), .auto_out_a_ready(out_a_ready[1]), .auto_out_a_bits(out_a_bits[1]),
    .auto_out_d_valid(out_d_valid[1]), .auto_out_d_ready(out_d_ready[1]), .auto_out_d_bits(out_d_bits[1]),
    .auto_in_d_valid(in_d_valid[1]), .auto_in_d_ready(in_d_ready[1]), .auto_in_d_bits(in_d_bits[1]),
    .a_count(a_cnt1), .d_count(d_cnt1));

  tl_buffer_param #(.A_DEPTH(1), .A_PIPE(1), .D_DEPTH(0)) u_dut2 (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid[2]), .auto_in_a_ready(in_a_ready[2]), .auto_in_a_bits(in_a_bits[2]),
    .auto_out_a_valid(out_a_valid[2]), .auto_out_a_ready(out_a_ready[2]), .auto_out_a_bits(out_a_bits[2]),
    .auto_out_d_valid(out_d_valid[2]), .auto_out_d_ready(out_d_ready[2]), .auto_out_d_bits(out_d_bits[2]),
    .auto_in_d_valid(in_d_valid[2]), .auto_in_d_ready(in_d_ready[2]), .auto_in_d_bits(in_d_bits[2]),
    .a_count(a_cnt2), .d_count(d_cnt2));

  tl_buffer_param #(.A_DEPTH(0), .D_DEPTH(0)) u_dut3 (
    .clock(clock), .reset(reset),
    .auto_in_a_valid(in_a_valid[3]), .auto_in_a_ready(in_a_ready[3]), .auto_in_a_bits(in_a_bits[3]),
    .auto_out_a_valid(out_a_valid[3]), .auto_out_a_ready(out_a_ready[3]), .auto_out_a_bits(out_a_bits[3]),
    .auto_out_d_valid(out_d_valid[3]), .auto_out_d_ready(out_d_ready[3]), .auto_out_d_bits(out_d_bits[3]),
    .auto_in_d_valid(in_d_valid[3]), .auto_in_d_ready(in_d_ready[3]), .auto_in_d_bits(in_d_bits[3]),
    .a_count(a_cnt3), .d_count(d_cnt3));

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [117:0] mk_a(input logic [31:0] addr, input logic [63:0] data);
    return {TL_A_PUT_FULL_DATA, 3'd0, 4'd3, 3'd1, addr, 8'hFF, data, 1'b0};
  endfunction

  function automatic logic [79:0] mk_d(input logic [63:0] data);
    return {TL_D_ACCESS_ACK_DATA, 2'd0, 4'd3, 3'd1, 2'd0, 1'b0, data, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic sb_pop_check(input string tag, input logic [127:0] obs);
    if (sb_q.size() == 0) begin
      check_val({tag, "_underflow"}, 128'(1), 128'(0));
    end else begin
      check_val(tag, obs, sb_q.pop_front());
    end
  endtask

  initial begin
    logic [127:0] r;
    int k;
    int got;
    for (int i = 0; i < 4; i++) begin
      in_a_valid[i] = 1'b0; in_a_bits[i] = '0; out_a_ready[i] = 1'b0;
      out_d_valid[i] = 1'b0; out_d_bits[i] = '0; in_d_ready[i] = 1'b0;
    end
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();

    // Reset state
    check_val("rst_a_count", 128'(a_cnt0), 128'(0));
    check_val("rst_out_a_valid", 128'(out_a_valid[0]), 128'(0));
    check_val("rst_in_a_ready", 128'(in_a_ready[0]), 128'(1));
    check_val("rst_d_count", 128'(d_cnt0), 128'(0));
    check_val("rst_in_d_valid", 128'(in_d_valid[0]), 128'(0));
    check_val("rst_out_d_ready", 128'(out_d_ready[0]), 128'(1));

    // Depth 2: fill with the manager stalled, then drain back-to-back
    sb_q.delete();
    out_a_ready[0] = 1'b0;
    in_a_valid[0] = 1'b1; in_a_bits[0] = mk_a(32'h1000, 64'h11);
    settle();
    check_val("d2_rdy0", 128'(in_a_ready[0]), 128'(1));
    sb_q.push_back(128'(mk_a(32'h1000, 64'h11)));
    tick();
    in_a_bits[0] = mk_a(32'h2000, 64'h22);
    settle();
    check_val("d2_cnt1", 128'(a_cnt0), 128'(1));
    check_val("d2_val1", 128'(out_a_valid[0]), 128'(1));
    check_val("d2_head1", 128'(out_a_bits[0]), 128'(mk_a(32'h1000, 64'h11)));
    sb_q.push_back(128'(mk_a(32'h2000, 64'h22)));
    tick();
    in_a_valid[0] = 1'b0;
    settle();
    check_val("d2_cnt2", 128'(a_cnt0), 128'(2));
    check_val("d2_full_rdy", 128'(in_a_ready[0]), 128'(0));
    check_val("d2_head2", 128'(out_a_bits[0]), 128'(mk_a(32'h1000, 64'h11)));
    out_a_ready[0] = 1'b1;
    settle();
    check_val("d2_drain_v0", 128'(out_a_valid[0]), 128'(1));
    sb_pop_check("d2_drain0", 128'(out_a_bits[0]));
    tick();
    check_val("d2_drain_cnt1", 128'(a_cnt0), 128'(1));
    check_val("d2_drain_v1", 128'(out_a_valid[0]), 128'(1));
    sb_pop_check("d2_drain1", 128'(out_a_bits[0]));
    tick();
    check_val("d2_drain_cnt0", 128'(a_cnt0), 128'(0));
    check_val("d2_drain_v2", 128'(out_a_valid[0]), 128'(0));

    // Depth 3 D channel: random client back-pressure, checks order and occupancy
    sb_q.delete();
    k = 0; got = 0;
    for (int cyc = 0; cyc < 300 && got < 7; cyc++) begin
      out_d_valid[1] = (k < 7);
      out_d_bits[1] = mk_d(64'(k));
      in_d_ready[1] = 1'($urandom_range(0, 1));
      settle();
      check_val("d3_count", 128'(d_cnt1), 128'(sb_q.size()));
      if (in_d_valid[1] && in_d_ready[1]) begin
        sb_pop_check("d3_order", 128'(in_d_bits[1]));
        got++;
      end
      if (out_d_valid[1] && out_d_ready[1]) begin
        sb_q.push_back(128'(mk_d(64'(k))));
        k++;
      end
      tick();
    end
    out_d_valid[1] = 1'b0;
    in_d_ready[1] = 1'b1;
    settle();
    check_val("d3_got7", 128'(got), 128'(7));
    check_val("d3_no_dup", 128'(in_d_valid[1]), 128'(0));
    check_val("d3_cnt_end", 128'(d_cnt1), 128'(0));

    // Depth 1 flow: empty queue forwards in the same cycle, stores nothing
    in_a_valid[1] = 1'b1; in_a_bits[1] = mk_a(32'h0, 64'hDEAD); out_a_ready[1] = 1'b1;
    settle();
    check_val("flow_valid", 128'(out_a_valid[1]), 128'(1));
    check_val("flow_bits", 128'(out_a_bits[1]), 128'(mk_a(32'h0, 64'hDEAD)));
    check_val("flow_rdy", 128'(in_a_ready[1]), 128'(1));
    check_val("flow_cnt", 128'(a_cnt1), 128'(0));
    tick();
    in_a_valid[1] = 1'b0;
    settle();
    check_val("flow_cnt_after", 128'(a_cnt1), 128'(0));
    check_val("flow_valid_after", 128'(out_a_valid[1]), 128'(0));

    // Depth 1 pipe: full queue keeps accepting while the head leaves
    sb_q.delete();
    out_a_ready[2] = 1'b0;
    in_a_valid[2] = 1'b1; in_a_bits[2] = mk_a(32'h100, 64'h1);
    sb_q.push_back(128'(mk_a(32'h100, 64'h1)));
    tick();
    in_a_bits[2] = mk_a(32'h200, 64'h2);
    settle();
    check_val("pipe_cnt_full", 128'(a_cnt2), 128'(1));
    check_val("pipe_rdy_stall", 128'(in_a_ready[2]), 128'(0));
    out_a_ready[2] = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      in_a_valid[2] = 1'b1;
      in_a_bits[2] = mk_a(32'(32'h100 * i), 64'(i));
      settle();
      check_val("pipe_rdy", 128'(in_a_ready[2]), 128'(1));
      check_val("pipe_valid", 128'(out_a_valid[2]), 128'(1));
      check_val("pipe_cnt", 128'(a_cnt2), 128'(1));
      sb_pop_check("pipe_order", 128'(out_a_bits[2]));
      sb_q.push_back(128'(mk_a(32'(32'h100 * i), 64'(i))));
      tick();
    end
    in_a_valid[2] = 1'b0;
    settle();
    check_val("pipe_last_v", 128'(out_a_valid[2]), 128'(1));
    sb_pop_check("pipe_last", 128'(out_a_bits[2]));
    tick();
    check_val("pipe_cnt_end", 128'(a_cnt2), 128'(0));

    // Depth 0 both channels: pure wires every cycle
    for (int i = 0; i < 20; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      in_a_valid[3] = r[0]; out_a_ready[3] = r[1];
      out_d_valid[3] = r[2]; in_d_ready[3] = r[3];
      in_a_bits[3] = r[117:0];
      out_d_bits[3] = r[127:48];
      settle();
      check_val("wire_a_valid", 128'(out_a_valid[3]), 128'(r[0]));
      check_val("wire_a_ready", 128'(in_a_ready[3]), 128'(r[1]));
      check_val("wire_a_bits", 128'(out_a_bits[3]), 128'(r[117:0]));
      check_val("wire_d_valid", 128'(in_d_valid[3]), 128'(r[2]));
      check_val("wire_d_ready", 128'(out_d_ready[3]), 128'(r[3]));
      check_val("wire_d_bits", 128'(in_d_bits[3]), 128'(r[127:48]));
      check_val("wire_counts", 128'({a_cnt3, d_cnt3}), 128'(0));
      tick();
    end

    // Reset with two beats held discards them
    out_a_ready[0] = 1'b0;
    in_a_valid[0] = 1'b1; in_a_bits[0] = mk_a(32'h1000, 64'h11);
    tick();
    in_a_bits[0] = mk_a(32'h2000, 64'h22);
    tick();
    in_a_valid[0] = 1'b0;
    settle();
    check_val("prerst_cnt", 128'(a_cnt0), 128'(2));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check_val("postrst_cnt", 128'(a_cnt0), 128'(0));
    check_val("postrst_valid", 128'(out_a_valid[0]), 128'(0));
    check_val("postrst_rdy", 128'(in_a_ready[0]), 128'(1));
    in_a_valid[0] = 1'b1; in_a_bits[0] = mk_a(32'h3000, 64'h33);
    tick();
    in_a_valid[0] = 1'b0;
    settle();
    check_val("postrst_first_v", 128'(out_a_valid[0]), 128'(1));
    check_val("postrst_first", 128'(out_a_bits[0]), 128'(mk_a(32'h3000, 64'h33)));
    check_val("postrst_cnt1", 128'(a_cnt0), 128'(1));
    out_a_ready[0] = 1'b1;
    tick();
    check_val("postrst_cnt0", 128'(a_cnt0), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
